// File: rtl/clock_set_controller.sv
// Front-panel control stage for the six-digit clock: button debounce, reset/set/start FSM,
// digit selection/increment and 24-hour wrap limits. Optional blink via CLOCK_SET_BLINK_EN.
module clock_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_sel,
  input  logic        btn_inc,
  output logic [3:0]  state,
  output logic [3:0]  identity_sel,
  output logic [23:0] set_digits,
  output logic [23:0] max_digits,
  output logic [5:0]  digit_blank
);

  typedef enum logic [3:0] {
    StReset = 4'd0,
    StSet   = 4'd1,
    StStart = 4'd3
  } state_e;

  logic [2:0]      sync1_q, sync2_q, acc_q, acc_d1_q;
  logic [DB_W-1:0] cnt_q [3];
  logic [2:0]      pulse;
  logic            mode_p, sel_p, inc_p;

  // Button bit order: 0 = mode, 1 = sel, 2 = inc.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      acc_q    <= '0;
      acc_d1_q <= '0;
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q  <= {btn_inc, btn_sel, btn_mode};
      sync2_q  <= sync1_q;
      acc_d1_q <= acc_q;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] == acc_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          acc_q[b] <= sync2_q[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  assign pulse  = acc_q & ~acc_d1_q;
  assign mode_p = pulse[0];
  assign sel_p  = pulse[1];
  assign inc_p  = pulse[2];

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] digit_q [6];
  logic [3:0] digit_d [6];
  logic [3:0] max_dig [6];

  // 24-hour limits; LHB is limited to 3 only in the 20s hours.
  always_comb begin
    max_dig[0] = 4'd9;
    max_dig[1] = 4'd5;
    max_dig[2] = 4'd9;
    max_dig[3] = 4'd5;
    max_dig[4] = (digit_q[5] == 4'd2) ? 4'd3 : 4'd9;
    max_dig[5] = 4'd2;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    digit_d = digit_q;
    unique case (state_q)
      StReset: begin
        for (int i = 0; i < 6; i++) digit_d[i] = 4'd0;
        if (mode_p) begin
          state_d = StSet;
          sel_d   = 4'd1;
        end
      end
      StSet: begin
        if (mode_p) begin
          state_d = StStart;
        end else if (sel_p) begin
          sel_d = (sel_q >= 4'd6) ? 4'd1 : sel_q + 4'd1;
        end else if (inc_p) begin
          for (int i = 0; i < 6; i++) begin
            if (sel_q == 4'(i + 1)) begin
              digit_d[i] = (digit_q[i] >= max_dig[i]) ? 4'd0 : digit_q[i] + 4'd1;
            end
          end
          // Entering the 20s hours pulls an out-of-range LHB down to 3.
          if (sel_q == 4'd6 && digit_q[5] == 4'd1 && digit_q[4] > 4'd3) begin
            digit_d[4] = 4'd3;
          end
        end
      end
      StStart: begin
        if (mode_p) begin
          state_d = StReset;
          for (int i = 0; i < 6; i++) digit_d[i] = 4'd0;
        end
      end
      default: begin
        state_d = StReset;
        sel_d   = 4'd1;
        for (int i = 0; i < 6; i++) digit_d[i] = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReset;
      sel_q   <= 4'd1;
      for (int i = 0; i < 6; i++) digit_q[i] <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      for (int i = 0; i < 6; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign state        = state_q;
  assign identity_sel = sel_q;

  always_comb begin
    set_digits = '0;
    max_digits = '0;
    for (int i = 0; i < 6; i++) begin
      set_digits[i*4 +: 4] = digit_q[i];
      max_digits[i*4 +: 4] = max_dig[i];
    end
  end

`ifdef CLOCK_SET_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != StSet) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  always_comb begin
    digit_blank = '0;
    for (int i = 0; i < 6; i++) begin
      if (sel_q == 4'(i + 1)) digit_blank[i] = blink_q;
    end
  end
`else
  assign digit_blank = 6'b0;
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a 4-cycle debounce.
module tb_clock_set_controller;

  logic        clk;
  logic        reset;
  logic [2:0]  btn;  // 0 = mode, 1 = sel, 2 = inc
  logic [3:0]  state;
  logic [3:0]  identity_sel;
  logic [23:0] set_digits;
  logic [23:0] max_digits;
  logic [5:0]  digit_blank;

  int n_cmp = 0;
  int n_bad = 0;

  clock_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .DB_W           (20),
    .BLINK_CYCLES   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn[0]),
    .btn_sel     (btn[1]),
    .btn_inc     (btn[2]),
    .state       (state),
    .identity_sel(identity_sel),
    .set_digits  (set_digits),
    .max_digits  (max_digits),
    .digit_blank (digit_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold a button pattern long enough to be accepted, then release long enough to settle.
  task automatic press(input logic [2:0] v);
    btn = v;
    repeat (8) @(negedge clk);
    btn = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    btn   = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", 24'(state), 24'd0);
    check("rst_sel", 24'(identity_sel), 24'd1);
    check("rst_digits", set_digits, 24'h000000);
    check("rst_blank", 24'(digit_blank), 24'd0);
    check("rst_max", max_digits, 24'h295959);

    // Press latency: state changes 2 + 4 + 1 edges after the press.
    btn = 3'b001;
    repeat (6) @(negedge clk);
    check("mode_lat_before", 24'(state), 24'd0);
    @(negedge clk);
    check("mode_lat_edge", 24'(state), 24'd1);
    repeat (3) @(negedge clk);
    btn = 3'b000;
    repeat (10) @(negedge clk);
    check("mode_single", 24'(state), 24'd1);

    // Three-cycle glitch must be rejected.
    btn = 3'b001;
    repeat (3) @(negedge clk);
    btn = 3'b000;
    repeat (10) @(negedge clk);
    check("glitch", 24'(state), 24'd1);

    for (int k = 1; k <= 11; k++) begin
      press(3'b100);
      check($sformatf("lsb_inc%0d", k), 24'(set_digits[3:0]), 24'(k % 10));
    end

    for (int k = 1; k <= 6; k++) begin
      press(3'b010);
      check($sformatf("sel%0d", k), 24'(identity_sel), 24'((k % 6) + 1));
    end

    // HHB = 1, LHB = 7, then HHB -> 2 clamps LHB to 3.
    repeat (5) press(3'b010);
    press(3'b100);
    check("hhb1", set_digits, 24'h100001);
    press(3'b010);
    repeat (4) press(3'b010);
    check("sel_lhb", 24'(identity_sel), 24'd5);
    repeat (7) press(3'b100);
    check("lhb7", set_digits, 24'h170001);
    press(3'b010);
    press(3'b100);
    check("clamp_digits", set_digits, 24'h230001);
    check("clamp_lhb_max", 24'(max_digits[19:16]), 24'd3);
    check("clamp_max", max_digits, 24'h235959);

    // Coincident mode + inc: mode wins.
    press(3'b101);
    check("coinc_state", 24'(state), 24'd3);
    check("coinc_digits", set_digits, 24'h230001);
    press(3'b100);
    check("start_inc_state", 24'(state), 24'd3);
    check("start_inc_digits", set_digits, 24'h230001);
    press(3'b001);
    check("start_to_reset", 24'(state), 24'd0);
    check("reset_clears", set_digits, 24'h000000);

    // Reset in the middle of set mode.
    press(3'b001);
    repeat (2) press(3'b100);
    press(3'b010);
    check("pre_rst_digits", set_digits, 24'h000002);
    check("pre_rst_sel", 24'(identity_sel), 24'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 24'(state), 24'd0);
    check("mid_rst_sel", 24'(identity_sel), 24'd1);
    check("mid_rst_digits", set_digits, 24'h000000);
    check("mid_rst_blank", 24'(digit_blank), 24'd0);

    // Reset while mode is held: accepted after a full debounce from reset release.
    btn = 3'b001;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("held_rst_before", 24'(state), 24'd0);
    @(negedge clk);
    check("held_rst_edge", 24'(state), 24'd1);
    repeat (6) @(negedge clk);
    btn = 3'b000;
    repeat (10) @(negedge clk);
    check("held_rst_once", 24'(state), 24'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
